// File: rtl/mskskinny_round_ctrl_if.sv
// Round-controller bus for the masked SKINNY-128 datapath: mode-controller handshake,
// datapath strobes and the shared round constant. rnd exists only with MSK_CST_REFRESH_EN.
interface mskskinny_round_ctrl_if #(
  parameter int d = 2
);
  // start/ready: a request is accepted in exactly the cycle where start=1 and ready=1;
  // start seen while ready=0 is dropped, never queued. load marks the accepting cycle.
  logic           start;
  logic           ready;
  logic           load;
  logic           round_en;
  logic [6*d-1:0] round_cst;
  logic [5:0]     round_idx;
  logic           last_round;
  logic           done;
  logic [1:0]     dbg_state;
`ifdef MSK_CST_REFRESH_EN
  logic [6*(d-1)-1:0] rnd;

  modport master (
    output start, rnd,
    input  ready, load, round_en, round_cst, round_idx, last_round, done, dbg_state
  );

  modport slave (
    input  start, rnd,
    output ready, load, round_en, round_cst, round_idx, last_round, done, dbg_state
  );
`else
  modport master (
    output start,
    input  ready, load, round_en, round_cst, round_idx, last_round, done, dbg_state
  );

  modport slave (
    input  start,
    output ready, load, round_en, round_cst, round_idx, last_round, done, dbg_state
  );
`endif
endinterface

// File: rtl/mskskinny_round_ctrl.sv
// Round sequencer for masked SKINNY-128: round-constant LFSR, d-share constant, round timing.
// Optional MSK_CST_REFRESH_EN: re-mask the constant shares from rnd at the start of every round.
module mskskinny_round_ctrl #(
  parameter int d       = 2,
  parameter int NROUNDS = 56,
  parameter int RND_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mskskinny_round_ctrl_if.slave   bus
);

  localparam int CW = (RND_LAT > 1) ? $clog2(RND_LAT) : 1;
  localparam int RW = 6 * (d - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(RND_LAT - 1);
  localparam logic [5:0]    IDX_LAST = 6'(NROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cyc, cyc_n;
  logic [5:0]     idx, idx_n;
  logic [5:0]     lfsr, lfsr_n;
  logic           enter_round;
  logic [RW-1:0]  masks;

  logic           ready_q;
  logic           round_en_q;
  logic           last_q;
  logic           done_q;
  logic [6*d-1:0] cst_q;

  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4] ^ 1'b1};
  endfunction

  // Bit-major sharing: bit i occupies [i*d +: d]; share 0 absorbs the masks of shares 1..d-1.
  function automatic logic [6*d-1:0] share_cst(input logic [5:0] rc, input logic [RW-1:0] m);
    logic [6*d-1:0] s;
    logic [d-2:0]   mi;
    s = '0;
    for (int i = 0; i < 6; i++) begin
      mi = m[i*(d-1) +: (d-1)];
      s[i*d] = rc[i] ^ (^mi);
      for (int j = 1; j < d; j++) begin
        s[i*d+j] = mi[j-1];
      end
    end
    return s;
  endfunction

`ifdef MSK_CST_REFRESH_EN
  assign masks = bus.rnd;
`else
  assign masks = '0;
`endif

  always_comb begin
    state_n     = state;
    cyc_n       = cyc;
    idx_n       = idx;
    lfsr_n      = lfsr;
    enter_round = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n     = S_RUN;
          cyc_n       = '0;
          idx_n       = '0;
          lfsr_n      = 6'h01;
          enter_round = 1'b1;
        end
      end
      S_RUN: begin
        if (cyc == CYC_LAST) begin
          if (idx == IDX_LAST) begin
            state_n = S_DONE;
            cyc_n   = '0;
            idx_n   = '0;
            lfsr_n  = '0;
          end else begin
            idx_n       = idx + 6'd1;
            cyc_n       = '0;
            lfsr_n      = lfsr_step(lfsr);
            enter_round = 1'b1;
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cyc_n   = '0;
        idx_n   = '0;
        lfsr_n  = '0;
      end
      default: begin
        state_n = S_IDLE;
        cyc_n   = '0;
        idx_n   = '0;
        lfsr_n  = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc        <= '0;
      idx        <= '0;
      lfsr       <= '0;
      ready_q    <= 1'b1;
      round_en_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      cst_q      <= '0;
    end else begin
      state      <= state_n;
      cyc        <= cyc_n;
      idx        <= idx_n;
      lfsr       <= lfsr_n;
      ready_q    <= (state_n == S_IDLE);
      round_en_q <= (state_n == S_RUN) && (cyc_n == CYC_LAST);
      last_q     <= (state_n == S_RUN) && (idx_n == IDX_LAST);
      done_q     <= (state_n == S_DONE);
      if (enter_round) begin
        cst_q <= share_cst(lfsr_n, masks);
      end else if (state_n != S_RUN) begin
        cst_q <= '0;
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.load       = ready_q & bus.start;
  assign bus.round_en   = round_en_q;
  assign bus.round_cst  = cst_q;
  assign bus.round_idx  = idx;
  assign bus.last_round = last_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_mskskinny_round_ctrl.sv
// Bench for mskskinny_round_ctrl: directed steps, per-cycle monitor and round-constant scoreboard.
// Build with MSK_CST_REFRESH_EN defined to exercise d=3 with random mask refresh.
module tb_mskskinny_round_ctrl;
`ifdef MSK_CST_REFRESH_EN
  localparam int D = 3;
`else
  localparam int D = 2;
`endif
  localparam int NR  = 56;
  localparam int LAT = 4;
  localparam int RW  = 6 * (D - 1);

  logic clk = 1'b0;
  logic rst;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc_cnt = 0;

  logic [5:0]    rc_tab [NR];
  logic [5:0]    exp_q[$];
  logic          run_active = 1'b0;
  int            t0 = 0;
  logic [RW-1:0] exp_mask = '0;

  mskskinny_round_ctrl_if #(.d(D)) bus ();

  mskskinny_round_ctrl #(.d(D), .NROUNDS(NR), .RND_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

`ifdef MSK_CST_REFRESH_EN
  initial bus.rnd = '0;
  always @(posedge clk) begin
    #1;
    bus.rnd = RW'($urandom);
  end
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget && bus.done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idx(input int target, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (n < budget && bus.round_idx !== 6'(target)) begin
      @(negedge clk);
      n++;
    end
    check("idx_timeout", 64'(n < budget), 64'd1);
  endtask

  // monitor + scoreboard
  always @(negedge clk) begin : mon
    int            rel;
    int            k;
    logic [5:0]    rc_obs;
    logic [RW-1:0] sh_obs;
    for (int i = 0; i < 6; i++) begin
      rc_obs[i] = ^bus.round_cst[i*D +: D];
      for (int j = 1; j < D; j++) begin
        sh_obs[i*(D-1)+j-1] = bus.round_cst[i*D+j];
      end
    end
    if (!rst) begin
      if (run_active) begin
        rel = cyc_cnt - t0;
        if (rel <= NR * LAT) begin
          k = (rel - 1) / LAT;
          check("round_idx", 64'(bus.round_idx), 64'(k));
          check("round_en", 64'(bus.round_en), 64'((rel % LAT) == 0));
          check("last_round", 64'(bus.last_round), 64'(k == NR - 1));
          check("busy_ready", 64'(bus.ready), 64'd0);
          check("busy_load", 64'(bus.load), 64'd0);
          check("busy_done", 64'(bus.done), 64'd0);
          check("rc_masks", 64'(sh_obs), 64'(exp_mask));
          check("sb_size", 64'(exp_q.size()), 64'(NR - k));
          if (exp_q.size() > 0) begin
            check("rc_value", 64'(rc_obs), 64'(exp_q[0]));
            if (bus.round_en === 1'b1) void'(exp_q.pop_front());
          end
`ifdef MSK_CST_REFRESH_EN
          if (bus.round_en === 1'b1 && k != NR - 1) exp_mask = bus.rnd;
`endif
        end else if (rel == NR * LAT + 1) begin
          check("done_pulse", 64'(bus.done), 64'd1);
          check("done_ready", 64'(bus.ready), 64'd0);
          check("done_round_en", 64'(bus.round_en), 64'd0);
          check("done_cst", 64'(bus.round_cst), 64'd0);
          check("done_last", 64'(bus.last_round), 64'd0);
          check("sb_empty", 64'(exp_q.size()), 64'd0);
        end else begin
          run_active = 1'b0;
        end
      end
      if (!run_active) begin
        check("idle_ready", 64'(bus.ready), 64'd1);
        check("idle_done", 64'(bus.done), 64'd0);
        check("idle_round_en", 64'(bus.round_en), 64'd0);
        check("idle_cst", 64'(bus.round_cst), 64'd0);
        check("idle_last", 64'(bus.last_round), 64'd0);
        check("idle_idx", 64'(bus.round_idx), 64'd0);
        check("idle_load", 64'(bus.load), 64'(bus.start));
        if (bus.start === 1'b1) begin
          run_active = 1'b1;
          t0 = cyc_cnt;
          for (int r = 0; r < NR; r++) exp_q.push_back(rc_tab[r]);
`ifdef MSK_CST_REFRESH_EN
          exp_mask = bus.rnd;
`endif
        end
      end
    end
  end

  // directed sequence
  initial begin
    rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
               6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
               6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
               6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A,
               6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22, 6'h04, 6'h09, 6'h13,
               6'h26, 6'h0C, 6'h19, 6'h32, 6'h25, 6'h0A};
    rst       = 1'b1;
    bus.start = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_load", 64'(bus.load), 64'd0);
    check("rst_round_en", 64'(bus.round_en), 64'd0);
    check("rst_cst", 64'(bus.round_cst), 64'd0);
    check("rst_idx", 64'(bus.round_idx), 64'd0);
    check("rst_last", 64'(bus.last_round), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // single encryption
    pulse_start();
    wait_done(400);
    repeat (3) @(posedge clk);

    // start pulsed while busy is dropped
    pulse_start();
    wait_idx(10, 200);
    pulse_start();
    wait_done(400);
    repeat (4) @(posedge clk);

    // start held high: back-to-back runs
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_done(400);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(400);
    repeat (3) @(posedge clk);

    // reset in round 20 aborts the run
    pulse_start();
    wait_idx(20, 200);
    @(posedge clk); #1;
    rst        = 1'b1;
    run_active = 1'b0;
    exp_q.delete();
    exp_mask   = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_cst", 64'(bus.round_cst), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    repeat (5) @(posedge clk);

    // fresh run after abort starts again from rc 01
    pulse_start();
    wait_done(400);
    repeat (3) @(posedge clk);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
